// File: rtl/key_schedule_ctrl.sv
// AES-128 key expansion sequencer: writes w0..w43 into an external round-key RAM
// using an external registered SubWord unit, then arbitrates cipher-core reads.
module key_schedule_ctrl #(
  parameter int ADDR_W = 6
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic [127:0]      key_in,
  input  logic              key_valid,
  output logic              key_ready,
  output logic              busy,
  output logic              done,
  output logic              keys_valid,
  output logic [31:0]       sub_in,
  input  logic [31:0]       sub_out,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              rk_rd_req,
  input  logic [ADDR_W-1:0] rk_rd_addr,
  output logic              rk_rd_grant,
  output logic              rk_rd_valid,
  output logic              rk_rd_err
);

  typedef enum logic [2:0] {IDLE, LOAD, ROT, SUBW, LIN} state_t;

  localparam logic [5:0] LAST_WORD = 6'd43;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  state_t           state_q, state_d;
  logic [5:0]       i_q, i_d;
  logic [7:0]       rcon_q, rcon_d;
  logic             keys_valid_q, keys_valid_d;
  logic             done_q, done_d;
  logic             rd_valid_q, rd_valid_d;
  logic             rd_err_q, rd_err_d;
  // win_q[0] is w[i-4], win_q[3] is w[i-1]
  logic [3:0][31:0] win_q, win_d;
  logic             wr;
  logic [31:0]      wr_word;

  always_comb begin
    state_d      = state_q;
    i_d          = i_q;
    rcon_d       = rcon_q;
    keys_valid_d = keys_valid_q;
    win_d        = win_q;
    done_d       = 1'b0;
    rd_valid_d   = 1'b0;
    rd_err_d     = 1'b0;
    key_ready    = 1'b0;
    rk_rd_grant  = 1'b0;
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    sub_in       = '0;
    wr           = 1'b0;
    wr_word      = '0;

    unique case (state_q)
      IDLE: begin
        key_ready = 1'b1;
        if (key_valid) begin
          win_d[0]     = key_in[127:96];
          win_d[1]     = key_in[95:64];
          win_d[2]     = key_in[63:32];
          win_d[3]     = key_in[31:0];
          i_d          = '0;
          rcon_d       = 8'h01;
          keys_valid_d = 1'b0;
          state_d      = LOAD;
        end else if (keys_valid_q && rk_rd_req) begin
          rk_rd_grant = 1'b1;
          rd_valid_d  = 1'b1;
          if (rk_rd_addr > ADDR_W'(LAST_WORD)) begin
            rd_err_d = 1'b1;
          end else begin
            mem_en   = 1'b1;
            mem_addr = rk_rd_addr;
          end
        end
      end
      LOAD: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = ADDR_W'(i_q);
        mem_wdata = win_q[i_q[1:0]];
        i_d       = i_q + 6'd1;
        if (i_q[1:0] == 2'd3) state_d = ROT;
      end
      ROT: begin
        sub_in  = rot_word(win_q[3]);
        state_d = SUBW;
      end
      SUBW: begin
        wr      = 1'b1;
        wr_word = win_q[0] ^ sub_out ^ {rcon_q, 24'h0};
        rcon_d  = xtime(rcon_q);
      end
      LIN: begin
        wr      = 1'b1;
        wr_word = win_q[0] ^ win_q[3];
      end
      default: state_d = IDLE;
    endcase

    // ----- shared write path for derived words -----
    if (wr) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = ADDR_W'(i_q);
      mem_wdata = wr_word;
      win_d     = {wr_word, win_q[3], win_q[2], win_q[1]};
      if (i_q == LAST_WORD) begin
        state_d      = IDLE;
        done_d       = 1'b1;
        keys_valid_d = 1'b1;
      end else begin
        i_d     = i_q + 6'd1;
        state_d = (i_q[1:0] == 2'd3) ? ROT : LIN;
      end
    end

    if (ARESET) begin
      key_ready   = 1'b0;
      rk_rd_grant = 1'b0;
      mem_en      = 1'b0;
      mem_we      = 1'b0;
      mem_addr    = '0;
      mem_wdata   = '0;
      sub_in      = '0;
    end
  end

  // ----- control registers -----
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q      <= IDLE;
      i_q          <= '0;
      rcon_q       <= 8'h01;
      keys_valid_q <= 1'b0;
      done_q       <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      i_q          <= i_d;
      rcon_q       <= rcon_d;
      keys_valid_q <= keys_valid_d;
      done_q       <= done_d;
      rd_valid_q   <= rd_valid_d;
      rd_err_q     <= rd_err_d;
    end
  end

  // ----- word window (data only) -----
  always_ff @(posedge ACLK) begin
    win_q <= win_d;
  end

  assign busy        = (state_q != IDLE) && !ARESET;
  assign done        = done_q;
  assign keys_valid  = keys_valid_q;
  assign rk_rd_valid = rd_valid_q;
  assign rk_rd_err   = rd_err_q;

endmodule
